// File: rtl/i2c_cmd_queue.sv
`default_nettype none
// =============================================================================
// Module   : i2c_cmd_queue
// Brief    : Command FIFO and one-at-a-time dispatcher in front of eeprom_top,
//            returning one response per command. Define I2C_CMDQ_TIMEOUT_EN
//            for the WAIT timeout with sticky halt.
// Revision : 1.0
// =============================================================================
module i2c_cmd_queue #(
    parameter int DEPTH          = 4,
    parameter int AW             = 7,
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [AW-1:0]              req_addr,
    input  logic [DW-1:0]              req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_wr,
    output logic [AW-1:0]              rsp_addr,
    output logic [DW-1:0]              rsp_rdata,
    output logic                       rsp_err,
    output logic                       m_newd,
    output logic                       m_wr,
    output logic [AW-1:0]              m_addr,
    output logic [DW-1:0]              m_wdata,
    input  logic [DW-1:0]              m_rdata,
    input  logic                       m_done,
    output logic                       busy,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] cmd_count
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_EW = 1 + AW + DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_cmd_queue: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
    end

    state_t             r_state;
    logic [c_EW-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_seen_low;
    logic [DW-1:0]      r_rdata;
    logic [c_EW-1:0]    w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_halted;
    logic               w_done_q;

`ifdef I2C_CMDQ_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TW-1:0]    r_timer;
    logic               r_err;
    logic               r_rsp_err;
    logic               r_halted;
    assign w_halted = r_halted;
    assign rsp_err  = r_rsp_err;
    assign halted   = r_halted;
`else
    assign w_halted = 1'b0;
    assign rsp_err  = 1'b0;
    assign halted   = 1'b0;
`endif

    assign w_head    = r_mem[r_rd_ptr];
    assign req_ready = (r_count != c_CW'(DEPTH));
    assign w_push    = req_valid & req_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !rsp_valid && !w_halted;
    // A done level only counts once it has been seen low after this command's issue.
    assign w_done_q  = m_done & r_seen_low;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);
    assign cmd_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_wr, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seen_low <= 1'b0;
            r_rdata    <= '0;
            m_newd     <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            rsp_valid  <= 1'b0;
            rsp_wr     <= 1'b0;
            rsp_addr   <= '0;
            rsp_rdata  <= '0;
`ifdef I2C_CMDQ_TIMEOUT_EN
            r_timer    <= '0;
            r_err      <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_halted   <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CW'(1);
            end

            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        m_wr       <= w_head[c_EW-1];
                        m_addr     <= w_head[DW +: AW];
                        m_wdata    <= w_head[DW-1:0];
                        m_newd     <= 1'b1;
                        r_rd_ptr   <= r_rd_ptr + c_PW'(1);
                        r_seen_low <= 1'b0;
`ifdef I2C_CMDQ_TIMEOUT_EN
                        r_timer    <= '0;
                        r_err      <= 1'b0;
`endif
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    m_newd <= 1'b0;
                    if (!m_done) begin
                        r_seen_low <= 1'b1;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_q) begin
                        r_rdata <= m_wr ? '0 : m_rdata;
                        r_state <= S_RESP;
                    end else begin
                        if (!m_done) begin
                            r_seen_low <= 1'b1;
                        end
`ifdef I2C_CMDQ_TIMEOUT_EN
                        if (r_timer == c_TW'(TIMEOUT_CYCLES - 1)) begin
                            r_err    <= 1'b1;
                            r_rdata  <= '0;
                            r_halted <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_timer <= r_timer + c_TW'(1);
                        end
`endif
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_wr    <= m_wr;
                    rsp_addr  <= m_addr;
                    rsp_rdata <= r_rdata;
`ifdef I2C_CMDQ_TIMEOUT_EN
                    r_rsp_err <= r_err;
`endif
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
